alu_result_serializer: RTL and testbench
========================================

ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

Interface
REQ-001 Parameter CLK_DIV, default 4, clock cycles per serial bit; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4, result FIFO entries; power of two, 2..16.
REQ-003 clock  input  1  single block clock, all state on rising edge.
REQ-004 resetb  input  1  asynchronous, active-low reset.
REQ-005 res_strobe  input  1  one-cycle pulse: capture current ALU results.
REQ-006 alu0_res  input  5  ALU 0 result, {carry, sum[3:0]}.
REQ-007 alu1_res  input  5  ALU 1 result, {carry, sum[3:0]}.
REQ-008 ovf_clr  input  1  clears sticky overflow flag.
REQ-009 tx  output  1  serial result stream, idle high.
REQ-010 busy  output  1  high while a frame is being shifted out.
REQ-011 fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 fifo_empty  output  1  FIFO holds zero entries.
REQ-013 overflow  output  1  sticky: a strobe was dropped.

Function
REQ-014 The FIFO entry SHALL be 10 bits, {alu1_res, alu0_res}, written on a rising edge where res_strobe=1 and fifo_full=0.
REQ-015 A strobe while fifo_full=1 SHALL be dropped and set overflow, even if a pop occurs in the same cycle.
REQ-016 overflow SHALL clear on ovf_clr=1; simultaneous drop and ovf_clr SHALL leave overflow set.
REQ-017 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL range 0..FIFO_DEPTH.
REQ-018 fifo_full and fifo_empty SHALL be registered and reflect the occupancy after each edge.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE -> START when FIFO is non-empty; the head entry SHALL be popped into a 10-bit shift register on that edge.
REQ-021 Each state SHALL hold tx for exactly CLK_DIV cycles using a bit-period counter that reloads on every state or bit change.
REQ-022 START drives tx=0; DATA drives the 10 bits LSB first (alu0_res[0] first, alu1_res[4] last); STOP drives tx=1.
REQ-023 DATA SHALL use a bit index counter 0..9; DATA exits to PARITY (if enabled) or STOP after bit 9.
REQ-024 STOP exit SHALL go to START (with a pop) if the FIFO is non-empty, otherwise to IDLE; back-to-back frames SHALL have no idle gap.
REQ-025 Latency: with FSM in IDLE and FIFO empty, a strobe captured at edge k SHALL make tx=0 from edge k+2.
REQ-026 tx SHALL be registered; busy=1 in every state except IDLE.
REQ-027 A strobe arriving during a frame SHALL be enqueued without disturbing the frame in progress.

Reset
REQ-028 On resetb=0, immediately: FSM=IDLE, tx=1, busy=0, FIFO pointers and count=0, fifo_empty=1, fifo_full=0, overflow=0, all counters 0.
REQ-029 Reset mid-frame SHALL abort the frame and discard all FIFO contents; the first frame after reset release SHALL carry only post-reset data.

Configuration
REQ-030 Macro RESULT_PARITY_EN: when defined, PARITY state SHALL be inserted after DATA, driving the even parity (XOR) of the 10 data bits for CLK_DIV cycles.
REQ-031 Without RESULT_PARITY_EN the PARITY state SHALL not exist and the frame is 12 bit periods; with it, 13 bit periods.

Verification
REQ-032 Idle, CLK_DIV=4: strobe with alu0_res=5'b10010, alu1_res=5'b00000 -> tx sequence 0 | 0,1,0,0,1,0,0,0,0,0 | (parity 0 if enabled) | 1, each bit 4 cycles; tx low at edge k+2.
REQ-033 Five strobes within one frame, FIFO_DEPTH=4 -> first popped immediately, next four queued, none dropped, five back-to-back frames with no idle gap, overflow=0.
REQ-034 Six strobes during first frame -> fifo_full=1, sixth dropped, overflow=1; ovf_clr pulse -> overflow=0; strobe plus ovf_clr while full -> overflow=1.
REQ-035 resetb low at bit 5 of DATA -> tx=1, busy=0, fifo_empty=1 asynchronously; no residual frame after release.
REQ-036 RESULT_PARITY_EN defined, alu0_res=5'b00001, alu1_res=5'b00011 -> parity bit 1, frame 13x CLK_DIV cycles; undefined -> 12x CLK_DIV cycles.

Source files
------------

// File: rtl/alu_result_serializer.sv
// Queues {alu1_res, alu0_res} captures in a small FIFO and shifts them out as UART-like frames.
// Define RESULT_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module alu_result_serializer #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       res_strobe,
  input  logic [4:0] alu0_res,
  input  logic [4:0] alu1_res,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [7:0]    DIV_M1  = 8'(CLK_DIV - 1);

`ifdef RESULT_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;
  logic [9:0]    head;
  logic [9:0]    mem [FIFO_DEPTH];
`ifdef RESULT_PARITY_EN
  logic          par_q, par_d;
`endif

  assign head = mem[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= {alu1_res, alu0_res};
  end

  always_comb begin
    push     = res_strobe & ~full_q;
    pop      = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    tx_d     = 1'b1;
`ifdef RESULT_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!empty_q) begin
          state_d = START;
          pop     = 1'b1;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = DIV_M1;
          bit_d   = '0;
        end else cnt_d = cnt_q - 8'd1;
      end
      DATA: begin
        tx_d = sh_q[0];
        if (cnt_q == '0) begin
          cnt_d = DIV_M1;
          if (bit_q == 4'd9) begin
`ifdef RESULT_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
            sh_d  = {1'b0, sh_q[9:1]};
          end
        end else cnt_d = cnt_q - 8'd1;
      end
`ifdef RESULT_PARITY_EN
      PARITY: begin
        tx_d = par_q;
        if (cnt_q == '0) begin
          state_d = STOP;
          cnt_d   = DIV_M1;
        end else cnt_d = cnt_q - 8'd1;
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (cnt_q == '0) begin
          if (!empty_q) begin
            state_d = START;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else cnt_d = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase

    // Both pop sites (IDLE and STOP) load the frame the same way.
    if (pop) begin
      sh_d  = head;
      cnt_d = DIV_M1;
      bit_d = '0;
`ifdef RESULT_PARITY_EN
      par_d = ^head;
`endif
    end

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    if (res_strobe && full_q) ovf_d = 1'b1;
    else if (ovf_clr)         ovf_d = 1'b0;
    else                      ovf_d = ovf_q;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
`ifdef RESULT_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
`ifdef RESULT_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: framing, latency, FIFO/overflow, async reset, frame length.
module tb_alu_result_serializer;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef RESULT_PARITY_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif
  localparam logic [9:0] VEC [8] = '{10'h012, 10'h3FF, 10'h155, 10'h2AA,
                                     10'h061, 10'h200, 10'h0F0, 10'h1C3};

  logic       clock = 1'b0;
  logic       resetb, res_strobe, ovf_clr;
  logic [4:0] alu0_res, alu1_res;
  logic       tx, busy, fifo_full, fifo_empty, overflow;
  int         errors = 0;
  int         checks = 0;

  alu_result_serializer #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock), .resetb(resetb), .res_strobe(res_strobe),
    .alu0_res(alu0_res), .alu1_res(alu1_res), .ovf_clr(ovf_clr),
    .tx(tx), .busy(busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame model: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic frame_bit(input logic [9:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 10) return d[i-1];
`ifdef RESULT_PARITY_EN
    if (i == 11) return ^d;
`endif
    return 1'b1;
  endfunction

  // Call right after a negedge; strobes are captured on the following posedges.
  task automatic burst(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      {alu1_res, alu0_res} = VEC[base+i];
      res_strobe = 1'b1;
      @(negedge clock);
    end
    res_strobe = 1'b0;
  endtask

  task automatic run_frames(input int n, input int base);
    @(negedge clock);
    @(negedge clock);
    check("tx_latency_k+1", tx, 1'b1);
    for (int f = 0; f < n; f++)
      for (int i = 0; i < NB*CLK_DIV; i++) begin
        @(negedge clock);
        check($sformatf("frame%0d_bit%0d", base+f, i/CLK_DIV), tx, frame_bit(VEC[base+f], i/CLK_DIV));
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb = 1'b0; res_strobe = 1'b0; ovf_clr = 1'b0;
    alu0_res = '0; alu1_res = '0;
    repeat (3) @(negedge clock);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_full", fifo_full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    resetb = 1'b1;
    @(negedge clock);

    // Single frame from idle, first vector is alu0=10010, alu1=00000
    fork
      burst(1, 0);
      begin
        @(negedge clock);
        check("A_nonempty", fifo_empty, 1'b0);
        check("A_idle_k", busy, 1'b0);
      end
      run_frames(1, 0);
    join
    check("A_busy_end", busy, 1'b0);
    check("A_tx_end", tx, 1'b1);
    check("A_empty_end", fifo_empty, 1'b1);
    @(negedge clock);

    // Five strobes: one popped, four fill the FIFO, five back-to-back frames
    fork
      burst(5, 1);
      begin
        repeat (5) @(negedge clock);
        check("B_full", fifo_full, 1'b1);
        check("B_ovf", overflow, 1'b0);
      end
      run_frames(5, 1);
    join
    check("B_ovf_end", overflow, 1'b0);
    check("B_empty_end", fifo_empty, 1'b1);
    check("B_busy_end", busy, 1'b0);
    @(negedge clock);

    // Six strobes: sixth dropped; clear; drop plus clear keeps overflow set
    fork
      burst(6, 0);
      begin
        repeat (6) @(negedge clock);
        check("C_full", fifo_full, 1'b1);
        check("C_ovf_set", overflow, 1'b1);
        ovf_clr = 1'b1;
        @(negedge clock);
        ovf_clr = 1'b0;
        check("C_ovf_clr", overflow, 1'b0);
        check("C_full2", fifo_full, 1'b1);
        ovf_clr = 1'b1;
        res_strobe = 1'b1;
        {alu1_res, alu0_res} = 10'h3E7;
        @(negedge clock);
        ovf_clr = 1'b0;
        res_strobe = 1'b0;
        check("C_ovf_drop_clr", overflow, 1'b1);
      end
      run_frames(5, 0);
    join
    check("C_ovf_sticky", overflow, 1'b1);
    check("C_empty_end", fifo_empty, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clock);
    ovf_clr = 1'b0;
    check("C_ovf_final", overflow, 1'b0);

    // Reset during DATA bit 5 with a second entry queued
    burst(2, 2);
    repeat (26) @(negedge clock);
    check("D_bit5", tx, frame_bit(VEC[2], 6));
    check("D_busy_pre", busy, 1'b1);
    resetb = 1'b0;
    #1;
    check("D_rst_tx", tx, 1'b1);
    check("D_rst_busy", busy, 1'b0);
    check("D_rst_empty", fifo_empty, 1'b1);
    check("D_rst_full", fifo_full, 1'b0);
    @(negedge clock);
    resetb = 1'b1;
    begin
      int activity;
      activity = 0;
      repeat (60) begin
        @(negedge clock);
        if (tx !== 1'b1 || busy !== 1'b0) activity++;
      end
      check("D_no_residual", activity, 0);
    end
    fork
      burst(1, 6);
      run_frames(1, 6);
    join
    @(negedge clock);

    // Frame length and parity vector alu0=00001, alu1=00011
    fork
      burst(1, 4);
      run_frames(1, 4);
      begin
        int n;
        n = 0;
        repeat (NB*CLK_DIV + 10) begin
          @(negedge clock);
          if (busy) n++;
        end
        check("F_frame_len", n, NB*CLK_DIV);
      end
    join
`ifdef RESULT_PARITY_EN
    check("F_parity_model", frame_bit(VEC[4], 11), 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
